// File: rtl/elevator_scheduler.sv
// Single-car elevator sequencer: latches floor calls, picks the next move with a SCAN policy,
// and times per-floor travel and door dwell.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 6,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 100000000,
    parameter int DOOR_CYCLES   = 200000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] in,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;

    logic [FLOOR_W-1:0]   eval_floor;
    logic                 at_last;
    logic                 up_req;
    logic                 dn_req;
    logic                 here;
    state_t               d_state;
    logic                 d_dir;
    logic                 d_moving;
    logic                 d_door;
    logic                 entering_door;
    logic [NUM_FLOORS-1:0] clr;

    // Decision is evaluated against the floor the car will occupy after this edge:
    // the arrival floor on a travel terminal count, otherwise the current floor.
    always_comb begin
        at_last    = 1'b0;
        eval_floor = floor;
        case (state)
            MOVE_UP: begin
                at_last    = (timer == TRAVEL_LAST);
                eval_floor = floor + FLOOR_W'(1);
            end
            MOVE_DOWN: begin
                at_last    = (timer == TRAVEL_LAST);
                eval_floor = floor - FLOOR_W'(1);
            end
            default: begin
                at_last    = 1'b0;
                eval_floor = floor;
            end
        endcase

        up_req = 1'b0;
        dn_req = 1'b0;
        here   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > eval_floor) up_req = up_req | pending[i];
            if (FLOOR_W'(i) < eval_floor) dn_req = dn_req | pending[i];
            if (FLOOR_W'(i) == eval_floor) here = here | pending[i];
        end

        d_dir = dir_up;
        if (here) begin
            d_state = DOOR;
        end else if (dir_up && up_req) begin
            d_state = MOVE_UP;
        end else if (!dir_up && dn_req) begin
            d_state = MOVE_DOWN;
        end else if (up_req) begin
            d_state = MOVE_UP;
            d_dir   = 1'b1;
        end else if (dn_req) begin
            d_state = MOVE_DOWN;
            d_dir   = 1'b0;
        end else begin
            d_state = IDLE;
        end
        d_moving = (d_state == MOVE_UP) || (d_state == MOVE_DOWN);
        d_door   = (d_state == DOOR);

        entering_door = d_door && ((state == IDLE) || at_last);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr[i] = (FLOOR_W'(i) == eval_floor) && (entering_door || (state == DOOR));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            floor     <= '0;
            dir_up    <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b0;
            pending   <= '0;
        end else begin
            pending <= (pending | in) & ~clr;
            case (state)
                IDLE: begin
                    if (d_state != IDLE) begin
                        state     <= d_state;
                        dir_up    <= d_dir;
                        timer     <= '0;
                        moving    <= d_moving;
                        door_open <= d_door;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (at_last) begin
                        floor     <= eval_floor;
                        state     <= d_state;
                        dir_up    <= d_dir;
                        timer     <= '0;
                        moving    <= d_moving;
                        door_open <= d_door;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DOOR: begin
                    if (timer == DOOR_LAST) begin
                        state     <= IDLE;
                        timer     <= '0;
                        moving    <= 1'b0;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: hand-derived vector table, directed corner sequences,
// and randomized presses checked against a countdown-based reference model.
module tb_elevator_scheduler;

    localparam int NF       = 6;
    localparam int FW       = 3;
    localparam int TRAVEL_C = 4;
    localparam int DOOR_C   = 3;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk;
    logic          reset;
    logic [NF-1:0] in;
    logic [FW-1:0] floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic [NF-1:0] pending;

    int tests  = 0;
    int failed = 0;

    // reference model state
    int m_floor = 0;
    int m_dir   = 1;
    int m_mode  = M_IDLE;
    int m_left  = 0;
    int m_pend  = 0;

    elevator_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .TRAVEL_CYCLES(TRAVEL_C),
        .DOOR_CYCLES  (DOOR_C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .floor    (floor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .pending  (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic [NF-1:0] vin;
        int            cyc;
        logic [FW-1:0] e_floor;
        logic          e_dir;
        logic          e_moving;
        logic          e_door;
        logic [NF-1:0] e_pend;
    } vec_t;

    vec_t vecs[20];

    function automatic void model_decide(input int f, input int p, input int d,
                                         output int mode, output int nd);
        int here_b, up_b, dn_b;
        here_b = (p >> f) & 1;
        up_b   = ((p >> (f + 1)) != 0) ? 1 : 0;
        dn_b   = ((p % (1 << f)) != 0) ? 1 : 0;
        nd     = d;
        if (here_b != 0) mode = M_DOOR;
        else if (d != 0 && up_b != 0) mode = M_UP;
        else if (d == 0 && dn_b != 0) mode = M_DOWN;
        else if (up_b != 0) begin mode = M_UP; nd = 1; end
        else if (dn_b != 0) begin mode = M_DOWN; nd = 0; end
        else mode = M_IDLE;
    endfunction

    // One clock edge of the reference: countdown timers, floors as integers, calls as an int mask.
    task automatic model_step();
        int f, d, mode, left, p, nmode, nd, clrf;
        if (reset) begin
            m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0; m_pend = 0;
            return;
        end
        f = m_floor; d = m_dir; mode = m_mode; left = m_left; p = m_pend;
        clrf = -1; nmode = M_IDLE; nd = d;
        case (mode)
            M_IDLE: begin
                model_decide(f, p, d, nmode, nd);
                if (nmode != M_IDLE) begin
                    mode = nmode; d = nd;
                    left = (nmode == M_DOOR) ? DOOR_C : TRAVEL_C;
                    if (nmode == M_DOOR) clrf = f;
                end
            end
            M_UP, M_DOWN: begin
                if (left == 1) begin
                    f = f + ((mode == M_UP) ? 1 : -1);
                    model_decide(f, p, d, nmode, nd);
                    mode = nmode; d = nd;
                    left = (nmode == M_DOOR) ? DOOR_C : TRAVEL_C;
                    if (nmode == M_DOOR) clrf = f;
                end else begin
                    left = left - 1;
                end
            end
            default: begin
                clrf = f;
                if (left == 1) mode = M_IDLE;
                else left = left - 1;
            end
        endcase
        p = p | int'(in);
        if (clrf >= 0) p = p & ~(1 << clrf);
        m_floor = f; m_dir = d; m_mode = mode; m_left = left; m_pend = p;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    // Apply vin for one edge (reset level for all cyc edges), then idle to cyc edges total.
    task automatic step(input logic r, input logic [NF-1:0] v, input int cyc);
        reset = r;
        in    = v;
        for (int i = 0; i < cyc; i++) begin
            tick();
            #1;
            in = '0;
        end
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [FW-1:0] ef, input logic ed,
                         input logic em, input logic eo, input logic [NF-1:0] ep);
        @(negedge clk);
        tests++;
        if ({floor, dir_up, moving, door_open, pending} !== {ef, ed, em, eo, ep}) begin
            failed++;
            $display("FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, want floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
                     name, floor, dir_up, moving, door_open, pending, ef, ed, em, eo, ep);
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = '0;

        vecs[0]  = '{1'b1, 6'b000000, 2,  3'd0, 1'b1, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{1'b0, 6'b000001, 1,  3'd0, 1'b1, 1'b0, 1'b0, 6'b000001};
        vecs[2]  = '{1'b0, 6'b000000, 1,  3'd0, 1'b1, 1'b0, 1'b1, 6'b000000};
        vecs[3]  = '{1'b0, 6'b000000, 2,  3'd0, 1'b1, 1'b0, 1'b1, 6'b000000};
        vecs[4]  = '{1'b0, 6'b000000, 1,  3'd0, 1'b1, 1'b0, 1'b0, 6'b000000};
        vecs[5]  = '{1'b0, 6'b001000, 1,  3'd0, 1'b1, 1'b0, 1'b0, 6'b001000};
        vecs[6]  = '{1'b0, 6'b000000, 1,  3'd0, 1'b1, 1'b1, 1'b0, 6'b001000};
        vecs[7]  = '{1'b0, 6'b000000, 4,  3'd1, 1'b1, 1'b1, 1'b0, 6'b001000};
        vecs[8]  = '{1'b0, 6'b000000, 4,  3'd2, 1'b1, 1'b1, 1'b0, 6'b001000};
        vecs[9]  = '{1'b0, 6'b000000, 3,  3'd2, 1'b1, 1'b1, 1'b0, 6'b001000};
        vecs[10] = '{1'b0, 6'b000000, 1,  3'd3, 1'b1, 1'b0, 1'b1, 6'b000000};
        vecs[11] = '{1'b0, 6'b000000, 2,  3'd3, 1'b1, 1'b0, 1'b1, 6'b000000};
        vecs[12] = '{1'b0, 6'b000000, 1,  3'd3, 1'b1, 1'b0, 1'b0, 6'b000000};
        vecs[13] = '{1'b0, 6'b100010, 1,  3'd3, 1'b1, 1'b0, 1'b0, 6'b100010};
        vecs[14] = '{1'b0, 6'b000000, 1,  3'd3, 1'b1, 1'b1, 1'b0, 6'b100010};
        vecs[15] = '{1'b0, 6'b000000, 8,  3'd5, 1'b1, 1'b0, 1'b1, 6'b000010};
        vecs[16] = '{1'b0, 6'b000000, 3,  3'd5, 1'b1, 1'b0, 1'b0, 6'b000010};
        vecs[17] = '{1'b0, 6'b000000, 1,  3'd5, 1'b0, 1'b1, 1'b0, 6'b000010};
        vecs[18] = '{1'b0, 6'b000000, 16, 3'd1, 1'b0, 1'b0, 1'b1, 6'b000000};
        vecs[19] = '{1'b0, 6'b000000, 3,  3'd1, 1'b0, 1'b0, 1'b0, 6'b000000};

        for (int k = 0; k < 20; k++) begin
            step(vecs[k].rst, vecs[k].vin, vecs[k].cyc);
            check($sformatf("vec%0d", k), vecs[k].e_floor, vecs[k].e_dir,
                  vecs[k].e_moving, vecs[k].e_door, vecs[k].e_pend);
        end

        // intermediate call while travelling 0->4
        step(1'b1, 6'b000000, 2);
        step(1'b0, 6'b010000, 1);
        step(1'b0, 6'b000000, 9);
        check("mid_at2", 3'd2, 1'b1, 1'b1, 1'b0, 6'b010000);
        step(1'b0, 6'b000000, 1);
        step(1'b0, 6'b001000, 1);
        check("mid_press3", 3'd2, 1'b1, 1'b1, 1'b0, 6'b011000);
        step(1'b0, 6'b000000, 2);
        check("mid_stop3", 3'd3, 1'b1, 1'b0, 1'b1, 6'b010000);
        step(1'b0, 6'b000000, 8);
        check("mid_stop4", 3'd4, 1'b1, 1'b0, 1'b1, 6'b000000);

        // reset during travel, timer=2 at floor 2
        step(1'b1, 6'b000000, 2);
        step(1'b0, 6'b100000, 1);
        step(1'b0, 6'b000000, 11);
        check("pre_abort", 3'd2, 1'b1, 1'b1, 1'b0, 6'b100000);
        step(1'b1, 6'b000000, 1);
        check("abort", 3'd0, 1'b1, 1'b0, 1'b0, 6'b000000);
        step(1'b0, 6'b000000, 10);
        check("abort_stays", 3'd0, 1'b1, 1'b0, 1'b0, 6'b000000);

        // randomized presses against the reference model
        step(1'b1, 6'b000000, 2);
        for (int c = 0; c < 3000; c++) begin
            int r;
            r     = $urandom_range(0, 99);
            reset = ($urandom_range(0, 999) == 0);
            if (r < 8) in = NF'(1 << $urandom_range(0, NF - 1));
            else if (r < 10) in = NF'($urandom_range(0, (1 << NF) - 1));
            else in = '0;
            tick();
            @(negedge clk);
            tests++;
            if ({floor, dir_up, moving, door_open, pending} !==
                {FW'(m_floor), m_dir[0], (m_mode == M_UP || m_mode == M_DOWN), (m_mode == M_DOOR), NF'(m_pend)}) begin
                failed++;
                $display("FAIL rand%0d: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, want floor=%0d dir_up=%0d mode=%0d pending=%b",
                         c, floor, dir_up, moving, door_open, pending, m_floor, m_dir, m_mode, NF'(m_pend));
            end
        end
        reset = 1'b0;
        in    = '0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
